// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave: command codes, FSM encoding, error bits.
package spi_slave_pkg;

  // Command field, frame bits [FRAME_W-1:FRAME_W-2]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // One-hot FSM encoding
  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StShiftIn  = 5'b00010,
    StWaitTx   = 5'b00100,
    StShiftOut = 5'b01000,
    StDone     = 5'b10000
  } state_e;

  // Error vector bit positions
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_ABORT   = 0;
  localparam int unsigned ERR_NO_ADDR = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first shift register for the read-data path, with a last-bit flag.
module spi_tx_shifter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_spi_slave_clk,
  input  logic              i_spi_slave_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_shift,
  output logic              o_msb,
  output logic              o_last
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;

  // Load takes priority; the counter saturates on the last bit so it never wraps
  always_ff @(posedge i_spi_slave_clk or negedge i_spi_slave_rst_n) begin
    if (!i_spi_slave_rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (i_load) begin
      shreg_q <= i_load_data;
      cnt_q   <= '0;
    end else if (i_shift) begin
      shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
      if (!o_last) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_msb  = shreg_q[DATA_W-1];
  assign o_last = (cnt_q == CntW'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_gen2.sv
// SPI slave front-end: deserialises {cmd, payload} frames, serialises read data after a
// tx handshake, and flags aborted frames, reads without an address and tx timeouts.
module spi_slave_gen2
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic                i_spi_slave_clk,
  input  logic                i_spi_slave_rst_n,
  input  logic                i_spi_slave_ss_bar,
  input  logic                i_spi_slave_mosi,
  input  logic [DATA_W-1:0]   i_spi_slave_tx_data,
  input  logic                i_spi_slave_tx_valid,
  output logic [DATA_W+1:0]   o_spi_slave_rx_data,
  output logic                o_spi_slave_rx_valid,
  output logic                o_spi_slave_miso,
  output logic                o_spi_slave_miso_valid,
  output logic                o_spi_slave_sready,
  output logic [ERR_W-1:0]    o_spi_slave_err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned BitCntW = $clog2(FRAME_W + 1);
  localparam int unsigned TmoCntW = $clog2(TX_TIMEOUT + 1);

  state_e               state_q;
  logic [FRAME_W-1:0]   rx_shreg_q;
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 rx_valid_q;
  logic [ERR_W-1:0]     err_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [TmoCntW-1:0]   tmo_cnt_q;
  logic                 addr_valid_q;

  logic [FRAME_W-1:0]   frame;
  logic [1:0]           frame_cmd;
  logic                 last_bit;
  logic                 tx_load;
  logic                 tx_shift;
  logic                 tx_msb;
  logic                 tx_last;

  // Frame as it will look once the current mosi bit is shifted in
  assign frame     = {rx_shreg_q[FRAME_W-2:0], i_spi_slave_mosi};
  assign frame_cmd = frame[FRAME_W-1 -: 2];
  assign last_bit  = (bit_cnt_q == BitCntW'(FRAME_W - 1));
  assign tx_load   = (state_q == StWaitTx) && !i_spi_slave_ss_bar && i_spi_slave_tx_valid;
  assign tx_shift  = (state_q == StShiftOut) && !i_spi_slave_ss_bar;

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx_shifter (
    .i_spi_slave_clk   (i_spi_slave_clk),
    .i_spi_slave_rst_n (i_spi_slave_rst_n),
    .i_load            (tx_load),
    .i_load_data       (i_spi_slave_tx_data),
    .i_shift           (tx_shift),
    .o_msb             (tx_msb),
    .o_last            (tx_last)
  );

  // Main FSM with registered rx/err pulses, bit/timeout counters and the address flag
  always_ff @(posedge i_spi_slave_clk or negedge i_spi_slave_rst_n) begin
    if (!i_spi_slave_rst_n) begin
      state_q      <= StIdle;
      rx_shreg_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      err_q        <= '0;
      bit_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      err_q      <= '0;
      unique case (state_q)
        StIdle: begin
          if (!i_spi_slave_ss_bar) begin
            rx_shreg_q <= frame;
            bit_cnt_q  <= BitCntW'(1);
            state_q    <= StShiftIn;
          end
        end
        StShiftIn: begin
          if (i_spi_slave_ss_bar) begin
            err_q[ERR_ABORT] <= 1'b1;
            state_q          <= StIdle;
          end else begin
            rx_shreg_q <= frame;
            if (last_bit) begin
              rx_data_q  <= frame;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
              state_q    <= StDone;
              case (frame_cmd)
                CMD_RD_ADDR: addr_valid_q <= 1'b1;
                CMD_RD_DATA: begin
                  if (addr_valid_q) begin
                    addr_valid_q <= 1'b0;
                    tmo_cnt_q    <= '0;
                    state_q      <= StWaitTx;
                  end else begin
                    err_q[ERR_NO_ADDR] <= 1'b1;
                  end
                end
                default: ;
              endcase
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StWaitTx: begin
          if (i_spi_slave_ss_bar) begin
            err_q[ERR_ABORT] <= 1'b1;
            state_q          <= StIdle;
          end else if (i_spi_slave_tx_valid) begin
            state_q <= StShiftOut;
          end else if (tmo_cnt_q == TmoCntW'(TX_TIMEOUT - 1)) begin
            err_q[ERR_TIMEOUT] <= 1'b1;
            state_q            <= StDone;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StShiftOut: begin
          if (i_spi_slave_ss_bar) begin
            err_q[ERR_ABORT] <= 1'b1;
            state_q          <= StIdle;
          end else if (tx_last) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // Stay here until deselected; no second frame within one select
          if (i_spi_slave_ss_bar) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_spi_slave_rx_data    = rx_data_q;
  assign o_spi_slave_rx_valid   = rx_valid_q;
  assign o_spi_slave_err        = err_q;
  assign o_spi_slave_sready     = (state_q == StIdle);
  assign o_spi_slave_miso_valid = (state_q == StShiftOut);
  assign o_spi_slave_miso       = (state_q == StShiftOut) & tx_msb;

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Directed bench for spi_slave_gen2 at DATA_W=8 and DATA_W=16 with an rx/miso scoreboard.
module tb_spi_slave_gen2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss;
  logic        mosi;
  logic [15:0] txd;
  logic        txv;
  logic        sel;  // 0: 8-bit DUT, 1: 16-bit DUT
  int          cur_dw;

  int n_checks = 0;
  int n_err    = 0;

  logic [17:0] exp_rx[$];
  logic        exp_miso[$];

  always #5 clk = ~clk;

  // 8-bit instance
  logic        ss8;
  logic [9:0]  rx8;
  logic        rxv8, miso8, misov8, srdy8;
  logic [2:0]  err8;

  // 16-bit instance
  logic        ss16;
  logic [17:0] rx16;
  logic        rxv16, miso16, misov16, srdy16;
  logic [2:0]  err16;

  assign ss8  = sel ? 1'b1 : ss;
  assign ss16 = sel ? ss : 1'b1;

  spi_slave_gen2 #(
    .DATA_W     (8),
    .TX_TIMEOUT (16)
  ) dut8 (
    .i_spi_slave_clk        (clk),
    .i_spi_slave_rst_n      (rst_n),
    .i_spi_slave_ss_bar     (ss8),
    .i_spi_slave_mosi       (mosi),
    .i_spi_slave_tx_data    (txd[7:0]),
    .i_spi_slave_tx_valid   (txv),
    .o_spi_slave_rx_data    (rx8),
    .o_spi_slave_rx_valid   (rxv8),
    .o_spi_slave_miso       (miso8),
    .o_spi_slave_miso_valid (misov8),
    .o_spi_slave_sready     (srdy8),
    .o_spi_slave_err        (err8)
  );

  spi_slave_gen2 #(
    .DATA_W     (16),
    .TX_TIMEOUT (16)
  ) dut16 (
    .i_spi_slave_clk        (clk),
    .i_spi_slave_rst_n      (rst_n),
    .i_spi_slave_ss_bar     (ss16),
    .i_spi_slave_mosi       (mosi),
    .i_spi_slave_tx_data    (txd),
    .i_spi_slave_tx_valid   (txv),
    .o_spi_slave_rx_data    (rx16),
    .o_spi_slave_rx_valid   (rxv16),
    .o_spi_slave_miso       (miso16),
    .o_spi_slave_miso_valid (misov16),
    .o_spi_slave_sready     (srdy16),
    .o_spi_slave_err        (err16)
  );

  // Observed outputs of whichever instance is selected
  logic [17:0] rx_m;
  logic        rxv_m, miso_m, misov_m, srdy_m;
  logic [2:0]  err_m;

  assign rx_m    = sel ? rx16 : {8'b0, rx8};
  assign rxv_m   = sel ? rxv16 : rxv8;
  assign miso_m  = sel ? miso16 : miso8;
  assign misov_m = sel ? misov16 : misov8;
  assign srdy_m  = sel ? srdy16 : srdy8;
  assign err_m   = sel ? err16 : err8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (DATA_W=%0d): observed %0h expected %0h", tag, cur_dw, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] mk_frame(input logic [1:0] cmd, input logic [15:0] pay,
                                           input int dw);
    logic [17:0] f;
    if (dw == 16) f = {cmd, pay};
    else          f = {8'b0, cmd, pay[7:0]};
    return f;
  endfunction

  // Shift nbits of the frame in MSB first; ss stays low afterwards
  task automatic drive_frame(input logic [1:0] cmd, input logic [15:0] pay, input int nbits);
    logic [17:0] f;
    int fw;
    f  = mk_frame(cmd, pay, cur_dw);
    fw = cur_dw + 2;
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = f[fw - 1 - i];
      cyc();
    end
  endtask

  task automatic deselect();
    ss = 1'b1;
    cyc();
  endtask

  // Scoreboard: compare rx frames and miso bits as the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (rxv_m) begin
        if (exp_rx.size() == 0) check("rx_unexpected", {31'b0, rxv_m}, 32'd0);
        else                    check("rx_data", {14'b0, rx_m}, {14'b0, exp_rx.pop_front()});
      end
      if (misov_m) begin
        if (exp_miso.size() == 0) check("miso_unexpected", {31'b0, misov_m}, 32'd0);
        else                      check("miso_bit", {31'b0, miso_m}, {31'b0, exp_miso.pop_front()});
      end
    end
  end

  task automatic push_miso(input logic [15:0] d);
    for (int i = cur_dw - 1; i >= 0; i--) exp_miso.push_back(d[i]);
  endtask

  task automatic run_width(input logic s);
    logic [15:0] tx_word;
    int cnt;
    int first_err;
    sel     = s;
    cur_dw  = s ? 16 : 8;
    tx_word = s ? 16'hA55A : 16'h00A5;
    cyc();

    // Write address: rx pulse one cycle after the last bit, no error
    exp_rx.push_back(mk_frame(2'b00, s ? 16'hC33C : 16'h003C, cur_dw));
    drive_frame(2'b00, s ? 16'hC33C : 16'h003C, cur_dw + 2);
    check("wr_rx_valid", {31'b0, rxv_m}, 32'd1);
    check("wr_err", {29'b0, err_m}, 32'd0);
    cyc();
    check("wr_rx_pulse_len", {31'b0, rxv_m}, 32'd0);
    check("wr_done_sready", {31'b0, srdy_m}, 32'd0);
    deselect();
    check("wr_idle_sready", {31'b0, srdy_m}, 32'd1);

    // Read address, then read data served after three idle cycles
    exp_rx.push_back(mk_frame(2'b10, 16'h0055, cur_dw));
    drive_frame(2'b10, 16'h0055, cur_dw + 2);
    check("rda_rx_valid", {31'b0, rxv_m}, 32'd1);
    deselect();
    cyc();
    exp_rx.push_back(mk_frame(2'b11, 16'h0000, cur_dw));
    drive_frame(2'b11, 16'h0000, cur_dw + 2);
    check("rdd_rx_valid", {31'b0, rxv_m}, 32'd1);
    check("rdd_err", {29'b0, err_m}, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    check("rdd_wait_no_miso", {31'b0, misov_m}, 32'd0);
    push_miso(tx_word);
    txd = tx_word;
    txv = 1'b1;
    cyc();
    txv = 1'b0;
    check("rdd_miso_start", {31'b0, misov_m}, 32'd1);
    cnt = 0;
    for (int i = 0; i < cur_dw + 4; i++) begin
      if (misov_m) cnt++;
      cyc();
    end
    check("rdd_miso_cycles", cnt, cur_dw);
    check("rdd_miso_end_valid", {31'b0, misov_m}, 32'd0);
    check("rdd_miso_end_done", {31'b0, srdy_m}, 32'd0);
    deselect();

    // Read data without a preceding read address
    exp_rx.push_back(mk_frame(2'b11, 16'h00F0, cur_dw));
    drive_frame(2'b11, 16'h00F0, cur_dw + 2);
    check("noaddr_rx_valid", {31'b0, rxv_m}, 32'd1);
    check("noaddr_err", {29'b0, err_m}, 32'd2);
    cyc();
    check("noaddr_err_pulse", {29'b0, err_m}, 32'd0);
    check("noaddr_no_miso", {31'b0, misov_m}, 32'd0);
    check("noaddr_done", {31'b0, srdy_m}, 32'd0);
    deselect();

    // Tx timeout: err[2] on the 16th waiting cycle
    exp_rx.push_back(mk_frame(2'b10, 16'h0011, cur_dw));
    drive_frame(2'b10, 16'h0011, cur_dw + 2);
    deselect();
    exp_rx.push_back(mk_frame(2'b11, 16'h0022, cur_dw));
    drive_frame(2'b11, 16'h0022, cur_dw + 2);
    first_err = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (first_err < 0 && err_m != 3'b000) begin
        first_err = i;
        check("tmo_err_code", {29'b0, err_m}, 32'd4);
      end
    end
    check("tmo_err_cycle", first_err, 16);
    check("tmo_done", {31'b0, srdy_m}, 32'd0);
    check("tmo_no_miso", {31'b0, misov_m}, 32'd0);
    deselect();

    // Abort after 5 bits of a write
    drive_frame(2'b01, 16'h00FF, 5);
    ss = 1'b1;
    cyc();
    check("abort_err", {29'b0, err_m}, 32'd1);
    check("abort_sready", {31'b0, srdy_m}, 32'd1);
    check("abort_no_rx", {31'b0, rxv_m}, 32'd0);
    cyc();
    check("abort_err_pulse", {29'b0, err_m}, 32'd0);

    // Reset in the middle of shifting out
    exp_rx.push_back(mk_frame(2'b10, 16'h0033, cur_dw));
    drive_frame(2'b10, 16'h0033, cur_dw + 2);
    deselect();
    exp_rx.push_back(mk_frame(2'b11, 16'h0044, cur_dw));
    drive_frame(2'b11, 16'h0044, cur_dw + 2);
    push_miso(tx_word);
    txd = tx_word;
    txv = 1'b1;
    cyc();
    txv = 1'b0;
    cyc();
    cyc();
    check("rst_pre_miso", {31'b0, misov_m}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_miso_valid", {31'b0, misov_m}, 32'd0);
    check("rst_miso", {31'b0, miso_m}, 32'd0);
    check("rst_sready", {31'b0, srdy_m}, 32'd1);
    check("rst_err", {29'b0, err_m}, 32'd0);
    check("rst_rx_data", {14'b0, rx_m}, 32'd0);
    exp_miso.delete();
    ss = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n  = 1'b0;
    ss     = 1'b1;
    mosi   = 1'b0;
    txd    = '0;
    txv    = 1'b0;
    sel    = 1'b0;
    cur_dw = 8;
    cyc();
    cyc();
    check("reset_sready8", {31'b0, srdy8}, 32'd1);
    check("reset_rxv8", {31'b0, rxv8}, 32'd0);
    check("reset_misov8", {31'b0, misov8}, 32'd0);
    check("reset_err8", {29'b0, err8}, 32'd0);
    check("reset_rx16", {14'b0, rx16}, 32'd0);
    check("reset_sready16", {31'b0, srdy16}, 32'd1);
    rst_n = 1'b1;
    cyc();

    run_width(1'b0);
    run_width(1'b1);

    cyc();
    check("rx_queue_drained", exp_rx.size(), 32'd0);
    check("miso_queue_drained", exp_miso.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
